// File: rtl/add_pipe_core_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : add_pipe_core_if
//  Purpose  : Operand/result bus for add_pipe_core. It carries the operand
//             valid/ready handshake in one direction and the result
//             valid/ready handshake plus the delivered-result counter in the
//             other.
//  Modports : master - drives operands and out_ready (upstream agent/bench)
//             slave  - the adder core
//  Signals  : in_valid/in_ready   operand handshake
//             a, b, cin           operands and carry-in
//             out_valid/out_ready result handshake
//             sum, cout           result value and carry-out
//             res_count           number of results delivered (wraps)
//  Revision : 1.0 - initial release
// ============================================================================
interface add_pipe_core_if #(
  parameter int ADD_WIDTH = 4,
  parameter int CNT_WIDTH = 8
);

  logic                 in_valid;
  logic                 in_ready;
  logic [ADD_WIDTH-1:0] a;
  logic [ADD_WIDTH-1:0] b;
  logic                 cin;
  logic                 out_valid;
  logic                 out_ready;
  logic [ADD_WIDTH-1:0] sum;
  logic                 cout;
  logic [CNT_WIDTH-1:0] res_count;

  modport master (
    output in_valid,
    output a,
    output b,
    output cin,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  cout,
    input  res_count
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  cin,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output cout,
    output res_count
  );

endinterface
`default_nettype wire

// File: rtl/add_pipe_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : add_pipe_core
//  Purpose  : Registered two-stage adder. Operand pairs are captured into a
//             stage-1 register under a valid/ready handshake; the registered
//             operands are added (sum + carry-out) and pushed into a 2-entry
//             result queue that drains under its own valid/ready handshake.
//             A counter reports how many results have been delivered.
//  Ports    : clk  - system clock, all state on the rising edge
//             rst  - asynchronous, active-low reset
//             bus  - add_pipe_core_if.slave (operand and result handshakes,
//                    operands, result, delivered-result counter)
//  Options  : ADD_SAT_EN - when defined, a result with carry-out set reports
//             sum as all ones (saturating); cout still reads 1. When
//             undefined the sum is modular.
//  Revision : 1.0 - initial release
// ============================================================================
module add_pipe_core #(
  parameter int ADD_WIDTH = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  add_pipe_core_if.slave bus
);

  // --------------------------------------------------------------------------
  // Stage 1: captured operands
  // --------------------------------------------------------------------------
  logic                 r_s1_valid;
  logic [ADD_WIDTH-1:0] r_s1_a;
  logic [ADD_WIDTH-1:0] r_s1_b;
  logic                 r_s1_cin;

  // --------------------------------------------------------------------------
  // Result queue (2 entries, circular) and output-side state
  // --------------------------------------------------------------------------
  logic [ADD_WIDTH-1:0] r_q_sum  [0:1];
  logic                 r_q_cout [0:1];
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [1:0]           r_q_count;
  logic [ADD_WIDTH-1:0] r_last_sum;
  logic                 r_last_cout;
  logic [CNT_WIDTH-1:0] r_res_count;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic [ADD_WIDTH:0]   w_total;
  logic [ADD_WIDTH-1:0] w_res_sum;
  logic                 w_res_cout;
  logic                 w_out_valid;
  logic                 w_push;
  logic                 w_pop;
  logic [1:0]           w_occupancy;
  logic                 w_in_ready;
  logic                 w_accept;

  // Adder is one bit wider than the operands so the carry lands in the MSB.
  assign w_total    = {1'b0, r_s1_a} + {1'b0, r_s1_b} + {{ADD_WIDTH{1'b0}}, r_s1_cin};
  assign w_res_cout = w_total[ADD_WIDTH];

`ifdef ADD_SAT_EN
  assign w_res_sum  = w_total[ADD_WIDTH] ? {ADD_WIDTH{1'b1}} : w_total[ADD_WIDTH-1:0];
`else
  assign w_res_sum  = w_total[ADD_WIDTH-1:0];
`endif

  assign w_out_valid = (r_q_count != 2'd0);
  assign w_pop       = w_out_valid & bus.out_ready;
  // Stage 1 always has room to drain: the occupancy limit below keeps
  // queue_count + s1_valid <= 2, so a valid stage 1 implies queue_count <= 1.
  assign w_push      = r_s1_valid;

  // Everything accepted but not yet delivered.
  assign w_occupancy = r_q_count + {1'b0, r_s1_valid};

  // A pop in the same cycle frees a slot, so a full pipe still accepts while
  // the consumer is draining (sustains one result per cycle). The reset input
  // gates ready directly so nothing is accepted while reset is held.
  assign w_in_ready  = rst & ((w_occupancy < 2'd2) | w_pop);
  assign w_accept    = bus.in_valid & w_in_ready;

  // --------------------------------------------------------------------------
  // Stage-1 register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_cin   <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_a   <= bus.a;
        r_s1_b   <= bus.b;
        r_s1_cin <= bus.cin;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Result queue: push from stage 1, pop on the output handshake. Push and pop
  // in the same cycle leave the count unchanged and preserve order because the
  // read and write pointers advance independently.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        r_q_sum[i]  <= '0;
        r_q_cout[i] <= 1'b0;
      end
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_q_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_q_sum[r_wr_ptr]  <= w_res_sum;
        r_q_cout[r_wr_ptr] <= w_res_cout;
        r_wr_ptr           <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_q_count <= r_q_count + 2'd1;
        2'b01:   r_q_count <= r_q_count - 2'd1;
        default: r_q_count <= r_q_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Last delivered result (shown while the queue is empty) and the
  // delivered-result counter, which wraps naturally at its width.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_sum  <= '0;
      r_last_cout <= 1'b0;
      r_res_count <= '0;
    end else if (w_pop) begin
      r_last_sum  <= r_q_sum[r_rd_ptr];
      r_last_cout <= r_q_cout[r_rd_ptr];
      r_res_count <= r_res_count + CNT_WIDTH'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: the queue head is presented directly, so sum/cout stay stable
  // for as long as the consumer stalls.
  // --------------------------------------------------------------------------
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.sum       = w_out_valid ? r_q_sum[r_rd_ptr]  : r_last_sum;
  assign bus.cout      = w_out_valid ? r_q_cout[r_rd_ptr] : r_last_cout;
  assign bus.res_count = r_res_count;

endmodule
`default_nettype wire
